star_motor_driver: RTL
======================

# star_motor_driver

Per-axis motor drive stage for the star-hiding mechanism, downstream of the star hiding state machine. Consumes its 4-bit motor command word and turns it into guarded drive signals for the grill and star motors. Each axis gets limit-switch cut-off, a reversal dead-time, a run timeout with sticky fault, and (optionally) a grill/star mechanical interlock.

## Interface
- DEADTIME_CYCLES, 16: idle cycles forced after any drive stop before the same axis may run again; must be ≥1
- TIMEOUT_CYCLES, 50000: maximum consecutive drive cycles before an axis faults; must be ≥2
- CNT_W, 16: width of the per-axis counters; must hold TIMEOUT_CYCLES-1 and DEADTIME_CYCLES-1
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_cmd  in  4  command from the hiding state machine: [3] grill open, [2] grill close, [1] star hide, [0] star extend
- i_grill_lim  in  2  grill limit switches, active-high: [1] fully open, [0] fully closed
- i_star_lim  in  2  star limit switches, active-high: [1] fully hidden, [0] fully up
- i_fault_clr  in  1  single-cycle fault clear, both axes
- o_grill_drv  out  2  grill motor: [1] open, [0] close; never both high
- o_star_drv  out  2  star motor: [1] hide, [0] extend; never both high
- o_fault  out  2  sticky timeout fault: [1] grill, [0] star
- o_busy  out  1  high while either axis is in RUN_A, RUN_B or DEAD

## Operation
- Two identical axis FSMs (grill: A=open, B=close; star: A=hide, B=extend), each with its own counter. States: IDLE, RUN_A, RUN_B, DEAD, FAULT.
- Outputs decode from the registered state: RUN_A drives bit [1], RUN_B drives bit [0], and every other state drives 00. o_fault bit is high only in FAULT.
- IDLE → RUN_A: request A high, request B low, A limit low, interlock permits. Counter cleared.
- IDLE → RUN_B: the same rule with A and B swapped.
- IDLE with both request bits high: invalid command. The axis stays in IDLE.
- IDLE with the target limit already high: the axis stays in IDLE.
- RUN_x → DEAD, when any of the following occurs:
  - the target limit goes high
  - request x drops
  - the opposite request rises
  - the interlock is withdrawn
- In DEAD, the counter is cleared on entry.
- RUN_x → FAULT: counter reaches TIMEOUT_CYCLES-1 and none of the DEAD conditions holds. A limit or a command drop in that same cycle wins, and the axis goes to DEAD.
- DEAD → IDLE after exactly DEADTIME_CYCLES cycles in DEAD. Commands are ignored during DEAD.
- FAULT → DEAD on i_fault_clr. FAULT ignores all commands otherwise.
- Reset: both FSMs go to IDLE, counters to 0, all outputs 0. DEAD is not entered after reset. Reset mid-run stops the drive on the edge where i_rst is sampled high.
- Counters saturate at their terminal value and never wrap.

## Timing
- Command/limit to drive change: 1 cycle. An input sampled at edge N is visible on the outputs after edge N.
- Limit cut-off: drive deasserts after the first edge at which the limit is sampled high.
- Maximum drive pulse: exactly TIMEOUT_CYCLES cycles, after which o_fault rises in the same cycle the drive falls.
- Minimum gap between any drive fall and the next drive rise on the same axis: DEADTIME_CYCLES cycles. A direct reversal command therefore yields DEADTIME_CYCLES zero cycles between opposite drives.
- i_fault_clr held high for several cycles has the same effect as a single-cycle pulse.

## Configuration
- STAR_MOTOR_INTERLOCK_EN defined:
  - Star may leave IDLE only while i_grill_lim[1]=1 and the grill FSM is IDLE. Losing either condition during a star run sends the star to DEAD.
  - Grill may leave IDLE only while the star FSM is IDLE or FAULT.
  - Simultaneous start requests in the same cycle: the grill wins and the star stays IDLE.
- Undefined: the interlock is always permitted and the axes run independently. All other behaviour is identical.

## Test plan
- Reset, then i_cmd=4'b1000 with grill limits 00 → o_grill_drv=10 one cycle later. Raise i_grill_lim[1] → o_grill_drv=00 next cycle, o_busy high for 16 more cycles, then low.
- Grill running open, then i_cmd switches to 4'b0100 → exactly 16 cycles of o_grill_drv=00, then 01.
- i_cmd=4'b0100 with no limit ever → o_grill_drv=01 for exactly TIMEOUT_CYCLES cycles, then o_fault=10 and drive 00. Further commands are ignored. i_fault_clr pulse → 16 cycles in DEAD, then the grill runs again if still commanded.
- With interlock enabled, i_cmd=4'b0010 and i_grill_lim=00 → o_star_drv stays 00. Set i_grill_lim=10 → o_star_drv=10. Drop i_grill_lim[1] → o_star_drv=00 next cycle.
- i_cmd=4'b1100 (both grill bits) → o_grill_drv stays 00. Assert i_rst mid star run → all outputs 0 on the next edge, and no fault is recorded.

Source files
------------

// File: rtl/star_motor_if.sv
// Command, limit-switch and drive/status bundle between the hiding state
// machine (master) and star_motor_driver (slave).
interface star_motor_if;
    logic [3:0] i_cmd;
    logic [1:0] i_grill_lim;
    logic [1:0] i_star_lim;
    logic       i_fault_clr;
    logic [1:0] o_grill_drv;
    logic [1:0] o_star_drv;
    logic [1:0] o_fault;
    logic       o_busy;

    modport master (
        output i_cmd, i_grill_lim, i_star_lim, i_fault_clr,
        input  o_grill_drv, o_star_drv, o_fault, o_busy
    );

    modport slave (
        input  i_cmd, i_grill_lim, i_star_lim, i_fault_clr,
        output o_grill_drv, o_star_drv, o_fault, o_busy
    );
endinterface

// File: rtl/star_motor_driver.sv
// Grill/star motor drive stage: limit cut-off, reversal dead-time, run timeout
// with sticky fault. Define STAR_MOTOR_INTERLOCK_EN for the grill/star interlock.
module star_motor_driver #(
    parameter int unsigned DEADTIME_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    star_motor_if.slave bus
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN_A = 3'd1;
    localparam logic [2:0] ST_RUN_B = 3'd2;
    localparam logic [2:0] ST_DEAD  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST    = CNT_W'(DEADTIME_CYCLES - 1);

    typedef struct packed {
        logic [2:0]       st;
        logic [CNT_W-1:0] cnt;
    } axis_t;

    axis_t grill_q, grill_d;
    axis_t star_q, star_d;
    logic  grill_permit;
    logic  star_permit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic axis_t start_or_idle(
        input logic req_a, input logic req_b,
        input logic lim_a, input logic lim_b,
        input logic permit
    );
        axis_t r;
        r.cnt = '0;
        if (req_a && !req_b && !lim_a && permit) begin
            r.st = ST_RUN_A;
        end else if (req_b && !req_a && !lim_b && permit) begin
            r.st = ST_RUN_B;
        end else begin
            r.st = ST_IDLE;
        end
        return r;
    endfunction

    function automatic axis_t axis_next(
        input axis_t cur,
        input logic  req_a, input logic req_b,
        input logic  lim_a, input logic lim_b,
        input logic  permit, input logic clr
    );
        axis_t r;
        r = cur;
        case (cur.st)
            ST_IDLE: r = start_or_idle(req_a, req_b, lim_a, lim_b, permit);
            ST_RUN_A: begin
                if (lim_a || !req_a || req_b || !permit) begin
                    r.st  = ST_DEAD;
                    r.cnt = '0;
                end else if (cur.cnt == TIMEOUT_LAST) begin
                    r.st = ST_FAULT;
                end else begin
                    r.cnt = sat_inc(cur.cnt);
                end
            end
            ST_RUN_B: begin
                if (lim_b || !req_b || req_a || !permit) begin
                    r.st  = ST_DEAD;
                    r.cnt = '0;
                end else if (cur.cnt == TIMEOUT_LAST) begin
                    r.st = ST_FAULT;
                end else begin
                    r.cnt = sat_inc(cur.cnt);
                end
            end
            ST_DEAD: begin
                // Last DEAD cycle applies the IDLE start rule directly, so a
                // reversal sees exactly DEADTIME_CYCLES idle cycles.
                if (cur.cnt == DEAD_LAST) begin
                    r = start_or_idle(req_a, req_b, lim_a, lim_b, permit);
                end else begin
                    r.cnt = sat_inc(cur.cnt);
                end
            end
            ST_FAULT: begin
                if (clr) begin
                    r.st  = ST_DEAD;
                    r.cnt = '0;
                end
            end
            default: begin
                r.st  = ST_IDLE;
                r.cnt = '0;
            end
        endcase
        return r;
    endfunction

    function automatic logic [1:0] drive_of(input logic [2:0] st);
        case (st)
            ST_RUN_A: return 2'b10;
            ST_RUN_B: return 2'b01;
            default:  return 2'b00;
        endcase
    endfunction

    function automatic logic is_busy(input logic [2:0] st);
        return (st == ST_RUN_A) || (st == ST_RUN_B) || (st == ST_DEAD);
    endfunction

    always_comb begin
        grill_permit = 1'b1;
        star_permit  = 1'b1;
`ifdef STAR_MOTOR_INTERLOCK_EN
        grill_permit = (star_q.st == ST_IDLE) || (star_q.st == ST_FAULT);
`endif
        grill_d = axis_next(grill_q, bus.i_cmd[3], bus.i_cmd[2],
                            bus.i_grill_lim[1], bus.i_grill_lim[0],
                            grill_permit, bus.i_fault_clr);
`ifdef STAR_MOTOR_INTERLOCK_EN
        // Grill starting in the same cycle keeps the star in IDLE.
        star_permit = bus.i_grill_lim[1] && (grill_q.st == ST_IDLE) &&
                      (grill_d.st == ST_IDLE);
`endif
        star_d = axis_next(star_q, bus.i_cmd[1], bus.i_cmd[0],
                           bus.i_star_lim[1], bus.i_star_lim[0],
                           star_permit, bus.i_fault_clr);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            grill_q <= '{st: ST_IDLE, cnt: '0};
            star_q  <= '{st: ST_IDLE, cnt: '0};
        end else begin
            grill_q <= grill_d;
            star_q  <= star_d;
        end
    end

    always_comb begin
        bus.o_grill_drv = drive_of(grill_q.st);
        bus.o_star_drv  = drive_of(star_q.st);
        bus.o_fault     = {grill_q.st == ST_FAULT, star_q.st == ST_FAULT};
        bus.o_busy      = is_busy(grill_q.st) || is_busy(star_q.st);
    end

endmodule
